decoder_scan_n: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder; the successor to the fixed 3-to-8 combinational decoder.
- Adds two things: an enable, and an auto-scan mode. In scan mode an internal index sweeps all outputs, holding each for a programmable dwell time (row/digit/chip-select scanning).
- Sits between control logic and multiplexed loads: LED/7-seg digit drivers, memory bank selects.

---
 rtl/decoder_scan_n.sv | 127 ++++++++++++
 tb/tb_decoder_scan_n.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// decoder_scan_n
//   Registered N_SEL-to-2**N_SEL one-hot decoder with enable and an auto-scan
//   mode. In scan mode an internal index sweeps every output, holding each one
//   for DWELL cycles. It is intended for row/digit/chip-select scanning.
//
// Parameters
//   N_SEL      select width (1..6); the decoder has 2**N_SEL outputs
//   DWELL      cycles each output stays active while scanning (>= 1)
//   ACTIVE_LOW 1 = Y is one-cold (inactive level all ones)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     block enable; 0 forces Y inactive
//   mode   0 = direct decode of A, 1 = auto-scan
//   A      direct-mode select / scan-mode load index
//   load   scan mode: jump to index A (beats advance and wrap)
//   Y      registered decode of idx (inactive while valid = 0)
//   idx    registered index currently decoded onto Y
//   valid  Y carries an active selection
//   wrap   one-cycle pulse when the scan index rolls over to 0
module decoder_scan_n #(
  parameter int N_SEL      = 3,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [N_SEL-1:0]      A,
  input  logic                  load,
  output logic [2**N_SEL-1:0]   Y,
  output logic [N_SEL-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int N_OUT = 2 ** N_SEL;
  localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N_SEL-1:0] IDX_LAST   = '1;
  localparam logic [N_OUT-1:0] Y_IDLE     = ACTIVE_LOW ? '1 : '0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [DW-1:0]    dwell_reg, dwell_next;
  logic [N_SEL-1:0] idx_reg, idx_next;
  logic             valid_reg, valid_next;
  logic             wrap_reg, wrap_next;
  logic [N_OUT-1:0] y_reg, y_next;
  logic [N_OUT-1:0] y_dec;

  // The target state depends only on en/mode; the current state only matters
  // for telling a SCAN entry (resume at held idx, fresh dwell) from a SCAN
  // continuation.
  always_comb begin
    state_next = ST_IDLE;
    dwell_next = '0;
    idx_next   = idx_reg;
    valid_next = 1'b0;
    wrap_next  = 1'b0;
    if (en) begin
      valid_next = 1'b1;
      if (!mode) begin
        state_next = ST_DIRECT;
        idx_next   = A;
      end else begin
        state_next = ST_SCAN;
        if (load) begin
          // load wins over advance/wrap; restart the dwell at A
          idx_next = A;
        end else if (state_reg != ST_SCAN) begin
          // entry: keep idx, dwell already cleared above
          idx_next = idx_reg;
        end else if (dwell_reg == DWELL_LAST) begin
          idx_next  = idx_reg + N_SEL'(1);
          wrap_next = (idx_reg == IDX_LAST);
        end else begin
          dwell_next = dwell_reg + DW'(1);
        end
      end
    end
  end

  // Decode the next index so Y lands in the same register stage as idx.
  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
      assign y_dec[gi] = (idx_next == N_SEL'(gi));
    end
  endgenerate

  always_comb begin
    y_next = Y_IDLE;
    if (valid_next) begin
      y_next = ACTIVE_LOW ? ~y_dec : y_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      dwell_reg <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      wrap_reg  <= 1'b0;
      y_reg     <= Y_IDLE;
    end else begin
      state_reg <= state_next;
      dwell_reg <= dwell_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      wrap_reg  <= wrap_next;
      y_reg     <= y_next;
    end
  end

  assign Y     = y_reg;
  assign idx   = idx_reg;
  assign valid = valid_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Self-checking bench for decoder_scan_n: a default build (N_SEL=3, DWELL=4)
// and an ACTIVE_LOW=1, DWELL=1 build sharing clock and reset.
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, load;
  logic [2:0] A;
  logic [7:0] Y;
  logic [2:0] idx;
  logic       valid, wrap;

  logic       en2, mode2, load2;
  logic [2:0] A2;
  logic [7:0] Y2;
  logic [2:0] idx2;
  logic       valid2, wrap2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(.N_SEL(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .A(A), .load(load),
    .Y(Y), .idx(idx), .valid(valid), .wrap(wrap)
  );

  decoder_scan_n #(.N_SEL(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .A(A2), .load(load2),
    .Y(Y2), .idx(idx2), .valid(valid2), .wrap(wrap2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; mode = 1'b0; load = 1'b0; A = 3'd0;
    en2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; A2 = 3'd0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (Y !== 8'h00 || valid !== 1'b0 || idx !== 3'd0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset: Y=%h valid=%b idx=%0d wrap=%b, required Y=00 valid=0 idx=0 wrap=0", Y, valid, idx, wrap);
    end
    checks++;
    if (Y2 !== 8'hFF || valid2 !== 1'b0) begin
      fails++;
      $display("FAIL reset_al: Y=%h valid=%b, required Y=ff valid=0", Y2, valid2);
    end
    rst_n = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_direct();
    logic [7:0] exp_y;
    do_reset();
    en = 1'b1; mode = 1'b0;
    for (int a = 0; a < 8; a++) begin
      A = 3'(a);
      step();
      exp_y = 8'h01 << a;
      checks++;
      if (Y !== exp_y || idx !== 3'(a) || valid !== 1'b1 || wrap !== 1'b0) begin
        fails++;
        $display("FAIL direct[%0d]: Y=%h idx=%0d valid=%b wrap=%b, required Y=%h idx=%0d valid=1 wrap=0", a, Y, idx, valid, wrap, exp_y, a);
      end
      $display("direct A=%0d Y=%h", a, Y);
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp_y;
    logic [2:0] exp_i;
    logic       exp_w;
    do_reset();
    en = 1'b1; mode = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      exp_i = 3'((c / 4) % 8);
      exp_y = 8'h01 << exp_i;
      exp_w = (c == 32);
      checks++;
      if (Y !== exp_y || idx !== exp_i || wrap !== exp_w || valid !== 1'b1) begin
        fails++;
        $display("FAIL scan[%0d]: Y=%h idx=%0d wrap=%b, required Y=%h idx=%0d wrap=%b", c, Y, idx, wrap, exp_y, exp_i, exp_w);
      end
    end
    $display("scan sweep 40 cycles checked");
  endtask

  task automatic test_load();
    do_reset();
    en = 1'b1; mode = 1'b1;
    repeat (32) step();  // now idx=7 with dwell=3
    checks++;
    if (idx !== 3'd7) begin
      fails++;
      $display("FAIL load_pre: idx=%0d, required 7", idx);
    end
    load = 1'b1; A = 3'd5;
    step();
    load = 1'b0;
    checks++;
    if (Y !== 8'h20 || idx !== 3'd5 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL load: Y=%h idx=%0d wrap=%b, required Y=20 idx=5 wrap=0", Y, idx, wrap);
    end
    for (int c = 1; c < 4; c++) begin
      step();
      checks++;
      if (Y !== 8'h20 || wrap !== 1'b0) begin
        fails++;
        $display("FAIL load_hold[%0d]: Y=%h wrap=%b, required Y=20 wrap=0", c, Y, wrap);
      end
    end
    step();
    checks++;
    if (Y !== 8'h40) begin
      fails++;
      $display("FAIL load_next: Y=%h, required 40", Y);
    end
    $display("load priority checked Y=%h", Y);
  endtask

  task automatic test_enable_gap();
    do_reset();
    en = 1'b1; mode = 1'b1;
    repeat (10) step();  // idx=2, mid-dwell
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (Y !== 8'h00 || valid !== 1'b0 || idx !== 3'd2) begin
        fails++;
        $display("FAIL gap[%0d]: Y=%h valid=%b idx=%0d, required Y=00 valid=0 idx=2", c, Y, valid, idx);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (Y !== 8'h04 || valid !== 1'b1) begin
        fails++;
        $display("FAIL regap[%0d]: Y=%h valid=%b, required Y=04 valid=1", c, Y, valid);
      end
    end
    step();
    checks++;
    if (Y !== 8'h08) begin
      fails++;
      $display("FAIL regap_next: Y=%h, required 08", Y);
    end
    $display("enable gap checked");
  endtask

  task automatic test_mode_switch();
    do_reset();
    en = 1'b1; mode = 1'b0; A = 3'd6;
    step();
    checks++;
    if (Y !== 8'h40) begin
      fails++;
      $display("FAIL mode_direct: Y=%h, required 40", Y);
    end
    mode = 1'b1; A = 3'd1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (Y !== 8'h40 || idx !== 3'd6) begin
        fails++;
        $display("FAIL mode_scan[%0d]: Y=%h idx=%0d, required Y=40 idx=6", c, Y, idx);
      end
    end
    step();
    checks++;
    if (Y !== 8'h80) begin
      fails++;
      $display("FAIL mode_next: Y=%h, required 80", Y);
    end
    $display("mode switch checked");
  endtask

  task automatic test_active_low();
    logic [7:0] exp_y;
    logic [2:0] exp_i;
    logic       exp_w;
    do_reset();
    en2 = 1'b1; mode2 = 1'b1;
    for (int c = 0; c < 18; c++) begin
      step();
      exp_i = 3'(c % 8);
      exp_y = ~(8'h01 << exp_i);
      exp_w = (c == 8) || (c == 16);
      checks++;
      if (Y2 !== exp_y || idx2 !== exp_i || wrap2 !== exp_w || valid2 !== 1'b1) begin
        fails++;
        $display("FAIL al_scan[%0d]: Y=%h idx=%0d wrap=%b, required Y=%h idx=%0d wrap=%b", c, Y2, idx2, wrap2, exp_y, exp_i, exp_w);
      end
    end
    $display("active-low dwell-1 scan checked");
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; mode = 1'b1;
    en2 = 1'b1; mode2 = 1'b1;
    repeat (6) step();
    #2;
    rst_n = 1'b0;  // between edges
    #1;
    checks++;
    if (Y !== 8'h00 || valid !== 1'b0 || idx !== 3'd0) begin
      fails++;
      $display("FAIL async_rst: Y=%h valid=%b idx=%0d, required Y=00 valid=0 idx=0", Y, valid, idx);
    end
    checks++;
    if (Y2 !== 8'hFF || valid2 !== 1'b0 || wrap2 !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_al: Y=%h valid=%b wrap=%b, required Y=ff valid=0 wrap=0", Y2, valid2, wrap2);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (Y !== 8'h01 || Y2 !== 8'hFE) begin
      fails++;
      $display("FAIL async_release: Y=%h Y_al=%h, required 01 and fe", Y, Y2);
    end
    $display("async reset checked");
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_load();
    test_enable_gap();
    test_mode_switch();
    test_active_low();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
